// File: rtl/regfile_wb_arb_pkg.sv
// Shared definitions for the regfile writeback arbiter: arbiter states,
// register-file geometry and small helpers used by the arbiter datapath.
package regfile_wb_arb_pkg;

  // Register-file geometry.
  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned REG_DATA_W = 32;

  // Width of the EX starvation wait counter (supports MAX_WAIT up to 15).
  localparam int unsigned WAIT_CNT_W = 4;

  // Arbiter states: NORMAL favours LD, STARVE forces a grant to EX.
  typedef enum logic [0:0] {
    NORMAL = 1'b0,
    STARVE = 1'b1
  } arb_state_e;

  // Saturating increment of the wait counter, capped at max_val.
  function automatic logic [WAIT_CNT_W-1:0] wait_cnt_sat_inc(
    input logic [WAIT_CNT_W-1:0] cnt,
    input logic [WAIT_CNT_W-1:0] max_val
  );
    logic [WAIT_CNT_W-1:0] res;
    if (cnt >= max_val) begin
      res = max_val;
    end else begin
      res = cnt + 4'd1;
    end
    return res;
  endfunction

  // Register x0 is hardwired to zero, so writes to it are swallowed.
  function automatic logic addr_is_writable(input logic [REG_ADDR_W-1:0] addr);
    return (addr != 5'd0);
  endfunction

endpackage

// File: rtl/regfile_wb_arb.sv
// Writeback arbiter in front of a single regfile write port.
// LD has priority over EX; EX is protected from starvation by a wait
// counter that forces one EX grant after MAX_WAIT stalled cycles.
// The winning request is registered and presented to the regfile one
// cycle later; writes to x0 are accepted but never raise wren.
module regfile_wb_arb
  import regfile_wb_arb_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  // Execute-stage writeback request
  input  logic                  ex_valid,
  output logic                  ex_ready,
  input  logic [REG_ADDR_W-1:0] ex_addr,
  input  logic [REG_DATA_W-1:0] ex_data,
  // Load-unit writeback request
  input  logic                  ld_valid,
  output logic                  ld_ready,
  input  logic [REG_ADDR_W-1:0] ld_addr,
  input  logic [REG_DATA_W-1:0] ld_data,
  // Regfile write port
  output logic                  wren,
  output logic [REG_ADDR_W-1:0] waddr,
  output logic [REG_DATA_W-1:0] wdata,
  // Hazard visibility for decode
  output logic                  pend_valid,
  output logic [REG_ADDR_W-1:0] pend_addr,
  // Arbiter is currently forcing an EX grant
  output logic                  starve
);

  localparam logic [WAIT_CNT_W-1:0] MAX_WAIT_C = WAIT_CNT_W'(MAX_WAIT);

  arb_state_e              state_q, state_d;
  logic [WAIT_CNT_W-1:0]   wait_cnt_q, wait_cnt_d;

  logic                    wren_q, wren_d;
  logic [REG_ADDR_W-1:0]   waddr_q, waddr_d;
  logic [REG_DATA_W-1:0]   wdata_q, wdata_d;

  logic                    ex_ready_s;
  logic                    ld_ready_s;
  logic                    ex_xfer_s;
  logic                    ld_xfer_s;

  // Grant decode: readies depend only on state and the other port's valid.
  always_comb begin
    ex_ready_s = 1'b0;
    ld_ready_s = 1'b0;
    case (state_q)
      NORMAL: begin
        ld_ready_s = 1'b1;
        ex_ready_s = ~ld_valid;
      end
      STARVE: begin
        ld_ready_s = 1'b0;
        ex_ready_s = 1'b1;
      end
      default: begin
        ld_ready_s = 1'b1;
        ex_ready_s = ~ld_valid;
      end
    endcase
  end

  // Grant rules above guarantee these are mutually exclusive.
  assign ex_xfer_s = ex_valid & ex_ready_s;
  assign ld_xfer_s = ld_valid & ld_ready_s;

  // Wait counter and arbiter next-state logic.
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    state_d    = state_q;

    if (ex_xfer_s || !ex_valid) begin
      wait_cnt_d = 4'd0;
    end else begin
      wait_cnt_d = wait_cnt_sat_inc(wait_cnt_q, MAX_WAIT_C);
    end

    case (state_q)
      NORMAL: begin
        if (ex_valid && !ex_ready_s && (wait_cnt_d == MAX_WAIT_C)) begin
          state_d = STARVE;
        end else begin
          state_d = NORMAL;
        end
      end
      STARVE: begin
        if (ex_xfer_s) begin
          state_d = NORMAL;
        end else begin
          state_d = STARVE;
        end
      end
      default: begin
        state_d = NORMAL;
      end
    endcase
  end

  // Write-port next value: capture the transferred request, else idle.
  always_comb begin
    wren_d  = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    if (ld_xfer_s) begin
      wren_d  = addr_is_writable(ld_addr);
      waddr_d = ld_addr;
      wdata_d = ld_data;
    end else if (ex_xfer_s) begin
      wren_d  = addr_is_writable(ex_addr);
      waddr_d = ex_addr;
      wdata_d = ex_data;
    end else begin
      wren_d  = 1'b0;
    end
  end

  // Arbiter state and wait counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= NORMAL;
      wait_cnt_q <= 4'd0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // Registered regfile write port; reset drops any write not yet presented.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wren_q  <= 1'b0;
      waddr_q <= 5'd0;
      wdata_q <= 32'd0;
    end else begin
      wren_q  <= wren_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
    end
  end

  assign ex_ready   = ex_ready_s;
  assign ld_ready   = ld_ready_s;
  assign wren       = wren_q;
  assign waddr      = waddr_q;
  assign wdata      = wdata_q;
  assign pend_valid = wren_q;
  assign pend_addr  = waddr_q;
  assign starve     = (state_q == STARVE);

endmodule

// File: tb/tb_regfile_wb_arb.sv
// Directed bench for regfile_wb_arb. The driver pushes the expected write
// into a queue when it issues a transfer; a monitor pops one entry per
// cycle in which a write is due and checks the write port every cycle.
module tb_regfile_wb_arb;

  logic        clk;
  logic        rst_n;
  logic        ex_valid;
  logic        ex_ready;
  logic [4:0]  ex_addr;
  logic [31:0] ex_data;
  logic        ld_valid;
  logic        ld_ready;
  logic [4:0]  ld_addr;
  logic [31:0] ld_data;
  logic        wren;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic        pend_valid;
  logic [4:0]  pend_addr;
  logic        starve;

  logic [36:0] exp_q[$];
  logic [31:0] rf_model [32];
  int          n_vec = 0;
  int          n_err = 0;

  regfile_wb_arb #(.MAX_WAIT(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ex_valid  (ex_valid),
    .ex_ready  (ex_ready),
    .ex_addr   (ex_addr),
    .ex_data   (ex_data),
    .ld_valid  (ld_valid),
    .ld_ready  (ld_ready),
    .ld_addr   (ld_addr),
    .ld_data   (ld_data),
    .wren      (wren),
    .waddr     (waddr),
    .wdata     (wdata),
    .pend_valid(pend_valid),
    .pend_addr (pend_addr),
    .starve    (starve)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // One arbitration cycle: drive, check readies/starve mid-cycle, then
  // record the expected write once the edge has passed.
  task automatic cyc(input logic ev, input logic [4:0] ea, input logic [31:0] ed,
                     input logic lv, input logic [4:0] la, input logic [31:0] ldd,
                     input logic x_exr, input logic x_ldr, input logic x_st);
    ex_valid = ev; ex_addr = ea; ex_data = ed;
    ld_valid = lv; ld_addr = la; ld_data = ldd;
    @(negedge clk);
    chk("ex_ready", 32'(ex_ready), 32'(x_exr));
    chk("ld_ready", 32'(ld_ready), 32'(x_ldr));
    chk("starve",   32'(starve),   32'(x_st));
    @(posedge clk);
    #1;
    if (lv && x_ldr) begin
      if (la != 5'd0) exp_q.push_back({la, ldd});
    end else if (ev && x_exr) begin
      if (ea != 5'd0) exp_q.push_back({ea, ed});
    end
  endtask

  task automatic idle();
    cyc(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 1'b1, 1'b0);
  endtask

  // Monitor: each cycle either the queued write appears or the port is idle.
  initial begin
    logic [36:0] e;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("wren",       32'(wren),       32'd1);
        chk("waddr",      32'(waddr),      32'(e[36:32]));
        chk("wdata",      wdata,           e[31:0]);
        chk("pend_valid", 32'(pend_valid), 32'd1);
        chk("pend_addr",  32'(pend_addr),  32'(e[36:32]));
      end else begin
        chk("wren_idle",       32'(wren),       32'd0);
        chk("pend_valid_idle", 32'(pend_valid), 32'd0);
      end
      if (wren) rf_model[waddr] = wdata;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 32; i++) rf_model[i] = 32'd0;
    rst_n = 1'b0;
    ex_valid = 1'b0; ex_addr = 5'd0; ex_data = 32'd0;
    ld_valid = 1'b0; ld_addr = 5'd0; ld_data = 32'd0;

    // Reset state
    #2;
    chk("rst_wren",     32'(wren),       32'd0);
    chk("rst_waddr",    32'(waddr),      32'd0);
    chk("rst_wdata",    wdata,           32'd0);
    chk("rst_pend_v",   32'(pend_valid), 32'd0);
    chk("rst_pend_a",   32'(pend_addr),  32'd0);
    chk("rst_starve",   32'(starve),     32'd0);
    chk("rst_ld_ready", 32'(ld_ready),   32'd1);
    chk("rst_ex_ready", 32'(ex_ready),   32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single LD write
    cyc(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'hDEADBEEF, 1'b0, 1'b1, 1'b0);
    idle();

    // Contention: LD wins four cycles, then forced EX grant, then LD again
    for (int i = 0; i < 4; i++)
      cyc(1'b1, 5'd3, 32'hE0E00003, 1'b1, 5'(8 + i), 32'h100 + 32'(i), 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 5'd3, 32'hE0E00003, 1'b1, 5'd12, 32'h00000104, 1'b1, 1'b0, 1'b1);
    cyc(1'b1, 5'd6, 32'hE0E00006, 1'b1, 5'd13, 32'h00000105, 1'b0, 1'b1, 1'b0);
    idle();

    // EX write to x0: accepted, no write pulse
    cyc(1'b1, 5'd0, 32'h12345678, 1'b0, 5'd0, 32'd0, 1'b1, 1'b1, 1'b0);
    idle();
    idle();

    // EX withdrawal: counter must restart from zero afterwards
    for (int i = 0; i < 2; i++)
      cyc(1'b1, 5'd10, 32'h0000000A, 1'b1, 5'(14 + i), 32'h200 + 32'(i), 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++)
      cyc(1'b0, 5'd0, 32'd0, 1'b1, 5'(16 + i), 32'h300 + 32'(i), 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++)
      cyc(1'b1, 5'd11, 32'h0000000B, 1'b1, 5'(20 + i), 32'h400 + 32'(i), 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 5'd11, 32'h0000000B, 1'b1, 5'd24, 32'h00000404, 1'b1, 1'b0, 1'b1);
    idle();

    // Same-address back-to-back: r5=1 by LD, then r5=2 by EX
    cyc(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'd1, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 5'd5, 32'd2, 1'b0, 5'd0, 32'd0, 1'b1, 1'b1, 1'b0);
    idle();
    idle();
    chk("rf_r5", rf_model[5], 32'd2);

    // Reset mid-write: LD transfer at edge N, reset before N+1
    for (int i = 0; i < 3; i++)
      cyc(1'b1, 5'd12, 32'h0000000C, 1'b1, 5'(25 + i), 32'h500 + 32'(i), 1'b0, 1'b1, 1'b0);
    ex_valid = 1'b1; ex_addr = 5'd12; ex_data = 32'h0000000C;
    ld_valid = 1'b1; ld_addr = 5'd9; ld_data = 32'h0000AA55;
    @(negedge clk);
    chk("pre_rst_ld_ready", 32'(ld_ready), 32'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    ex_valid = 1'b0;
    ld_valid = 1'b0;
    #1;
    chk("midrst_wren",   32'(wren),   32'd0);
    chk("midrst_starve", 32'(starve), 32'd0);
    chk("midrst_waddr",  32'(waddr),  32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    idle();
    idle();
    // Counter restarted by reset: no starve after one contended cycle
    cyc(1'b1, 5'd12, 32'h0000000C, 1'b1, 5'd28, 32'h00000600, 1'b0, 1'b1, 1'b0);
    idle();
    idle();

    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arb.md
REGFILE_WB_ARB -- requirements
Module: regfile_wb_arb

Interface
REQ-001 SHALL have parameter MAX_WAIT, default 4, meaning the number of consecutive cycles EX may be stalled before it is forcibly granted (legal range 1..15).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have ports ex_valid  input  1 and ex_ready  output  1: execute-stage writeback handshake.
REQ-005 SHALL have ports ex_addr  input  5 and ex_data  input  32: execute-stage destination register and result.
REQ-006 SHALL have ports ld_valid  input  1 and ld_ready  output  1: load-unit writeback handshake.
REQ-007 SHALL have ports ld_addr  input  5 and ld_data  input  32: load destination register and data.
REQ-008 SHALL have ports wren  output  1, waddr  output  5 and wdata  output  32: registered drive of the 32-entry regfile write port.
REQ-009 SHALL have ports pend_valid  output  1 and pend_addr  output  5: a write is being presented to the regfile this cycle, for decode hazard checks.
REQ-010 SHALL have port starve  output  1: the arbiter is in state STARVE.

Function
REQ-011 SHALL treat a transfer as occurring on a rising edge where valid and ready are both 1 on the same port; at most one transfer SHALL occur per cycle.
REQ-012 SHALL, in state NORMAL, set ld_ready=1, and SHALL set ex_ready=1 only when ld_valid=0.
REQ-013 SHALL keep a wait counter wait_cnt of 4 bits, incremented when ex_valid=1 and ex_ready=0, saturating at MAX_WAIT, and cleared on an EX transfer or when ex_valid=0.
REQ-014 SHALL enter state STARVE on the edge where wait_cnt would reach MAX_WAIT.
REQ-015 SHALL, in state STARVE, set ex_ready=1 and ld_ready=0, and SHALL return to NORMAL on the edge of the EX transfer.
REQ-016 SHALL have exactly two states, NORMAL and STARVE; no other transitions are legal.
REQ-017 SHALL, one cycle after a transfer, present wren=1, waddr=addr and wdata=data of the transferred request (latency 1).
REQ-018 SHALL accept a transfer with addr=0 (ready asserted as normal) but SHALL then hold wren=0; waddr and wdata are don't-care in that case.
REQ-019 SHALL hold wren=0 in any cycle not following a transfer; waddr and wdata SHALL hold their last value.
REQ-020 SHALL drive pend_valid equal to wren and pend_addr equal to waddr.
REQ-021 SHALL make ready independent of the same port's valid, with no combinational path from ready to valid.
REQ-022 SHALL, when both ports are valid in NORMAL with wait_cnt=MAX_WAIT-1, grant LD this cycle and grant EX on the next cycle via STARVE.
REQ-023 SHALL permit back-to-back writes to the same address; the later transfer wins.

Reset
REQ-024 SHALL, while rst_n=0, force state=NORMAL, wait_cnt=0, wren=0, waddr=0, wdata=0, pend_valid=0, pend_addr=0 and starve=0.
REQ-025 SHALL discard any registered write that has not yet been presented when reset is asserted mid-operation; no wren pulse SHALL follow reset release without a new transfer.
REQ-026 SHALL leave ex_ready and ld_ready at their NORMAL-state values during reset; upstream sees no transfer because reset gates state.

Structure
REQ-027 SHALL take the arbiter state enum (NORMAL, STARVE) and the register address width constant (5) from the shared defines package.
REQ-028 SHALL be a single module with no sub-modules; it instantiates no regfile and connects to regfile_32b at the level above.

Verification
REQ-029 SHALL cover single LD: ld_valid=1, ld_addr=7, ld_data=0xDEADBEEF -> ld_ready=1; next cycle wren=1, waddr=7, wdata=0xDEADBEEF.
REQ-030 SHALL cover contention with MAX_WAIT=4: both valid continuously, distinct data -> LD granted cycles 0-3, starve=1 and EX granted at cycle 4, LD granted at cycle 5.
REQ-031 SHALL cover an x0 write: ex_valid=1, ex_addr=0, ex_data=0x12345678, ld idle -> ex_ready=1; following cycle wren=0.
REQ-032 SHALL cover EX withdrawal: ex_valid high 2 cycles while LD is busy, then low -> wait_cnt returns to 0 and no STARVE entry.
REQ-033 SHALL cover reset mid-write: a transfer on edge N, rst_n=0 before edge N+1 -> wren=0 at N+1 and after release until a new transfer.
REQ-034 SHALL cover same-address sequence: LD writes r5=1 then EX writes r5=2 on consecutive cycles -> two wren pulses, reading r5 afterwards returns 2.
